// File: rtl/wm8731_pkg.sv
// Shared WM8731 codec definitions: device address, register word type,
// power-up register table and the configuration sequencer state encoding.
package wm8731_pkg;

   localparam logic [7:0] WM8731_DEV_ADDR = 8'h34;

   typedef logic [15:0] reg_word_t;

   // Entries beyond the active count are never issued with the default NUM_CMDS
   localparam reg_word_t WM8731_INIT_TABLE [16] = '{
      16'h1E00,   // reset
      16'h0815,   // analog audio path
      16'h0A00,   // digital audio path
      16'h0C00,   // power down control
      16'h0E42,   // I2S, master, 16-bit
      16'h1019,   // USB mode, 32 kHz
      16'h1201,   // interface active
      16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
      16'h0000, 16'h0000, 16'h0000, 16'h0000
   };

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      GAP,
      DONE,
      ERROR
   } seq_state_t;

endpackage

// File: rtl/i2c_config_sequencer.sv
// Walks the WM8731 init table and hands each register word to the I2C frame
// engine as a 24-bit {address, word} frame, retrying NACKed frames.
module i2c_config_sequencer
   import wm8731_pkg::*;
#(
   parameter int unsigned NUM_CMDS   = 7,
   parameter logic [7:0]  DEV_ADDR   = WM8731_DEV_ADDR,
   parameter int unsigned MAX_RETRY  = 3,
   parameter int unsigned GAP_CYCLES = 4
)(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   output logic        o_busy,
   output logic        o_finished,
   output logic        o_error,
   output logic [3:0]  o_index,
   output logic        o_cmd_valid,
   output logic [23:0] o_cmd_data,
   input  logic        i_cmd_ready,
   input  logic        i_done,
   input  logic        i_nack
);

   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [3:0]       LAST_IDX  = 4'(NUM_CMDS - 1);
   localparam logic [2:0]       RETRY_LIM = 3'(MAX_RETRY);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

   seq_state_t       r_state,     w_state;
   logic [3:0]       r_index,     w_index;
   logic [2:0]       r_retry,     w_retry;
   logic [GAP_W-1:0] r_gap,       w_gap;
   logic             r_busy,      w_busy;
   logic             r_finished,  w_finished;
   logic             r_error,     w_error;
   logic             r_cmd_valid, w_cmd_valid;
   logic [23:0]      r_cmd_data,  w_cmd_data;
   logic             w_start_ok;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_index     <= '0;
         r_retry     <= '0;
         r_gap       <= '0;
         r_busy      <= 1'b0;
         r_finished  <= 1'b0;
         r_error     <= 1'b0;
         r_cmd_valid <= 1'b0;
         r_cmd_data  <= '0;
      end else begin
         r_state     <= w_state;
         r_index     <= w_index;
         r_retry     <= w_retry;
         r_gap       <= w_gap;
         r_busy      <= w_busy;
         r_finished  <= w_finished;
         r_error     <= w_error;
         r_cmd_valid <= w_cmd_valid;
         r_cmd_data  <= w_cmd_data;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_index     = r_index;
      w_retry     = r_retry;
      w_gap       = r_gap;
      w_busy      = r_busy;
      w_finished  = 1'b0;
      w_error     = r_error;
      w_cmd_valid = r_cmd_valid;
      w_cmd_data  = r_cmd_data;

      w_start_ok = i_start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));

      case (r_state)
         IDLE, ERROR: ;
         ISSUE: begin
            if (i_cmd_ready) begin
               w_state     = WAIT;
               w_cmd_valid = 1'b0;
            end
         end
         WAIT: begin
            // A ready that coincides with done is irrelevant here; only done is acted on
            if (i_done) begin
               if (!i_nack) begin
                  if (r_index == LAST_IDX) begin
                     w_state    = DONE;
                     w_finished = 1'b1;
                     w_busy     = 1'b0;
                  end else begin
                     w_index = r_index + 4'd1;
                     w_retry = '0;
                     w_gap   = '0;
                     w_state = GAP;
                  end
               end else if (r_retry < RETRY_LIM) begin
                  w_retry = r_retry + 3'd1;
                  w_gap   = '0;
                  w_state = GAP;
               end else begin
                  w_state = ERROR;
                  w_error = 1'b1;
                  w_busy  = 1'b0;
               end
            end
         end
         GAP: begin
            if (r_gap == GAP_LAST) begin
               w_state     = ISSUE;
               w_gap       = '0;
               w_cmd_valid = 1'b1;
               w_cmd_data  = {DEV_ADDR, WM8731_INIT_TABLE[r_index]};
            end else begin
               w_gap = r_gap + GAP_W'(1);
            end
         end
         DONE:    w_state = IDLE;
         default: w_state = IDLE;
      endcase

      // Start from any resting state restarts the table at entry 0
      if (w_start_ok) begin
         w_state     = ISSUE;
         w_index     = '0;
         w_retry     = '0;
         w_gap       = '0;
         w_busy      = 1'b1;
         w_error     = 1'b0;
         w_cmd_valid = 1'b1;
         w_cmd_data  = {DEV_ADDR, WM8731_INIT_TABLE[0]};
      end
   end

   assign o_busy      = r_busy;
   assign o_finished  = r_finished;
   assign o_error     = r_error;
   assign o_index     = r_index;
   assign o_cmd_valid = r_cmd_valid;
   assign o_cmd_data  = r_cmd_data;

endmodule
